// File: rtl/r2_sdf_stage_if.sv
// Sample stream bundle for one radix-2 SDF stage.
// The master drives input samples and the slave (the stage) returns indexed results.
interface r2_sdf_stage_if #(
  parameter int W = 8,
  parameter int D = 4
);
  localparam int IW = $clog2(2 * D);

  logic              in_valid;
  logic [2*W-1:0]    in_data;
  logic              out_valid;
  logic [2*W-1:0]    out_data;
  logic [IW-1:0]     out_idx;

  modport master (
    output in_valid,
    output in_data,
    input  out_valid,
    input  out_data,
    input  out_idx
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output out_valid,
    output out_data,
    output out_idx
  );
endinterface

// File: rtl/r2_sdf_stage.sv
// Radix-2 DIF single-path delay-feedback stage: butterfly across a 2D frame,
// twiddle on the difference half, two registered pipeline stages.
module r2_sdf_stage #(
  parameter int W     = 8,
  parameter int D     = 4,
  parameter int FRAC  = 6,
  parameter int TW_W  = 8,
  parameter int SCALE = 0
) (
  input  logic          clk,
  input  logic          rst,
  r2_sdf_stage_if.slave bus
);
  localparam int IW    = $clog2(2 * D);
  localparam int AW    = (D > 1) ? $clog2(D) : 1;
  localparam int ROM_N = 32'sd1 <<< AW;
  localparam int PW    = W + TW_W + 1;
  localparam real PI   = 3.14159265358979323846;

  localparam logic [IW-1:0]        D_IDX    = IW'(D);
  localparam logic [IW-1:0]        LAST_IDX = IW'(2 * D - 1);
  localparam logic [IW-1:0]        ONE_IDX  = IW'(32'd1);
  localparam logic signed [PW-1:0] RND      = PW'(64'sd1) <<< (FRAC - 1);

  function automatic int round_nearest(input real x);
    int r;
    if (x >= 0.0) begin
      r = $rtoi(x + 0.5);
    end else begin
      r = -$rtoi(0.5 - x);
    end
    return r;
  endfunction

  function automatic logic signed [W-1:0] sat_w(input logic signed [PW-1:0] v);
    logic signed [W-1:0] r;
    if (v[PW-1:W-1] == {(PW-W+1){v[PW-1]}}) begin
      r = v[W-1:0];
    end else if (v[PW-1]) begin
      r = {1'b1, {(W-1){1'b0}}};
    end else begin
      r = {1'b0, {(W-1){1'b1}}};
    end
    return r;
  endfunction

  // Butterfly results are either halved (no overflow possible) or clamped.
  function automatic logic signed [W-1:0] fit_w(input logic signed [W:0] v);
    logic signed [W-1:0] r;
    if (SCALE != 0) begin
      r = v[W:1];
    end else begin
      r = sat_w(PW'(v));
    end
    return r;
  endfunction

  // Twiddle ROM, evaluated at elaboration; padding entries are never addressed.
  logic signed [TW_W-1:0] rom_re_s [ROM_N];
  logic signed [TW_W-1:0] rom_im_s [ROM_N];

  for (genvar g = 0; g < ROM_N; g++) begin : g_rom
    if (g < D) begin : g_used
      localparam real SCL = real'(32'sd1 <<< FRAC);
      localparam real ANG = PI * real'(g) / real'(D);
      localparam int  C   = round_nearest(SCL * $cos(ANG));
      localparam int  S   = round_nearest(SCL * $sin(ANG));
      assign rom_re_s[g] = TW_W'(C);
      assign rom_im_s[g] = TW_W'(-S);
    end else begin : g_pad
      assign rom_re_s[g] = {TW_W{1'b0}};
      assign rom_im_s[g] = {TW_W{1'b0}};
    end
  end

  logic [IW-1:0]          cnt_r;
  logic                   primed_r;
  logic [2*W-1:0]         buf_r [D];

  logic                   phase_b_s;
  logic [AW-1:0]          tw_addr_s;
  logic signed [W-1:0]    buf_re_s, buf_im_s, x_re_s, x_im_s;
  logic signed [W:0]      sum_re_s, sum_im_s, dif_re_s, dif_im_s;
  logic signed [W-1:0]    s_re_s, s_im_s, d_re_s, d_im_s;
  logic [2*W-1:0]         push_s;

  logic                   s1_valid_r;
  logic                   s1_diff_r;
  logic [IW-1:0]          s1_idx_r;
  logic signed [W-1:0]    s1_re_r, s1_im_r;
  logic signed [TW_W-1:0] tw_re_r, tw_im_r;

  logic signed [PW-1:0]   prod_re_s, prod_im_s, rnd_re_s, rnd_im_s;
  logic signed [W-1:0]    mul_re_s, mul_im_s;

  logic                   out_valid_r;
  logic [2*W-1:0]         out_data_r;
  logic [IW-1:0]          out_idx_r;

  // Butterfly on the oldest buffer entry and the incoming sample.
  always_comb begin
    phase_b_s = (cnt_r >= D_IDX);
    tw_addr_s = AW'(cnt_r);
    buf_re_s  = buf_r[D-1][2*W-1:W];
    buf_im_s  = buf_r[D-1][W-1:0];
    x_re_s    = bus.in_data[2*W-1:W];
    x_im_s    = bus.in_data[W-1:0];
    sum_re_s  = {buf_re_s[W-1], buf_re_s} + {x_re_s[W-1], x_re_s};
    sum_im_s  = {buf_im_s[W-1], buf_im_s} + {x_im_s[W-1], x_im_s};
    dif_re_s  = {buf_re_s[W-1], buf_re_s} - {x_re_s[W-1], x_re_s};
    dif_im_s  = {buf_im_s[W-1], buf_im_s} - {x_im_s[W-1], x_im_s};
    s_re_s    = fit_w(sum_re_s);
    s_im_s    = fit_w(sum_im_s);
    d_re_s    = fit_w(dif_re_s);
    d_im_s    = fit_w(dif_im_s);
    if (phase_b_s) begin
      push_s = {d_re_s, d_im_s};
    end else begin
      push_s = bus.in_data;
    end
  end

  // Feedback delay line; contents are masked by priming, so no reset is needed.
  always_ff @(posedge clk) begin
    if (!rst && bus.in_valid) begin
      for (int i = D - 1; i > 0; i--) begin
        buf_r[i] <= buf_r[i-1];
      end
      buf_r[0] <= push_s;
    end
  end

  // Frame counter, priming flag and stage-1 register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r      <= {IW{1'b0}};
      primed_r   <= 1'b0;
      s1_valid_r <= 1'b0;
      s1_diff_r  <= 1'b0;
      s1_idx_r   <= {IW{1'b0}};
      s1_re_r    <= {W{1'b0}};
      s1_im_r    <= {W{1'b0}};
      tw_re_r    <= {TW_W{1'b0}};
      tw_im_r    <= {TW_W{1'b0}};
    end else if (bus.in_valid) begin
      cnt_r      <= (cnt_r == LAST_IDX) ? {IW{1'b0}} : cnt_r + ONE_IDX;
      primed_r   <= primed_r | phase_b_s;
      s1_valid_r <= phase_b_s | primed_r;
      s1_diff_r  <= ~phase_b_s;
      tw_re_r    <= rom_re_s[tw_addr_s];
      tw_im_r    <= rom_im_s[tw_addr_s];
      if (phase_b_s) begin
        s1_idx_r <= cnt_r - D_IDX;
        s1_re_r  <= s_re_s;
        s1_im_r  <= s_im_s;
      end else begin
        s1_idx_r <= cnt_r + D_IDX;
        s1_re_r  <= buf_re_s;
        s1_im_r  <= buf_im_s;
      end
    end else begin
      s1_valid_r <= 1'b0;
    end
  end

  // Full-precision complex multiply, round half-up, saturate.
  always_comb begin
    prod_re_s = PW'(s1_re_r) * PW'(tw_re_r) - PW'(s1_im_r) * PW'(tw_im_r);
    prod_im_s = PW'(s1_re_r) * PW'(tw_im_r) + PW'(s1_im_r) * PW'(tw_re_r);
    rnd_re_s  = (prod_re_s + RND) >>> FRAC;
    rnd_im_s  = (prod_im_s + RND) >>> FRAC;
    mul_re_s  = sat_w(rnd_re_s);
    mul_im_s  = sat_w(rnd_im_s);
  end

  // Stage-2 output register; sums pass through so both paths have equal latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {(2*W){1'b0}};
      out_idx_r   <= {IW{1'b0}};
    end else begin
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        out_idx_r <= s1_idx_r;
        if (s1_diff_r) begin
          out_data_r <= {mul_re_s, mul_im_s};
        end else begin
          out_data_r <= {s1_re_r, s1_im_r};
        end
      end
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_idx   = out_idx_r;

endmodule

// File: tb/tb_r2_sdf_stage.sv
// Scoreboard bench: a frame-level reference model predicts results for a
// SCALE=0 and a SCALE=1 instance fed with identical stimulus.
module tb_r2_sdf_stage;
  localparam int W    = 8;
  localparam int D    = 4;
  localparam int FRAC = 6;
  localparam int TW_W = 8;
  localparam int N    = 2 * D;
  localparam int IW   = $clog2(N);

  typedef struct {
    logic [2*W-1:0] data;
    int             idx;
    int             due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  exp_t q0[$];
  exp_t q1[$];

  int tw_re[D], tw_im[D];
  int cur_re[N], cur_im[N];
  int pend_re[2][D], pend_im[2][D];
  bit primed_m;
  int pos_m;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  r2_sdf_stage_if #(.W(W), .D(D)) bus0 ();
  r2_sdf_stage_if #(.W(W), .D(D)) bus1 ();

  r2_sdf_stage #(.W(W), .D(D), .FRAC(FRAC), .TW_W(TW_W), .SCALE(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  r2_sdf_stage #(.W(W), .D(D), .FRAC(FRAC), .TW_W(TW_W), .SCALE(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  function automatic int rnd(real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    else return -$rtoi(0.5 - x);
  endfunction

  function automatic int clampw(int v);
    if (v > 127) return 127;
    else if (v < -128) return -128;
    else return v;
  endfunction

  function automatic int fit(int v, int s);
    if (s != 0) return v >>> 1;
    else return clampw(v);
  endfunction

  task automatic push_exp(int s, int re, int im, int idx, int due);
    exp_t e;
    e.data = {W'(re), W'(im)};
    e.idx  = idx;
    e.due  = due;
    if (s == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic model_reset();
    pos_m    = 0;
    primed_m = 1'b0;
  endtask

  // One accepted sample at frame position pos_m, accepted on edge number edge_n.
  task automatic model_accept(int re, int im, int edge_n);
    int k, dr, di, mr, mi;
    cur_re[pos_m] = re;
    cur_im[pos_m] = im;
    if (pos_m < D) begin
      if (primed_m) begin
        for (int s = 0; s < 2; s++) begin
          dr = pend_re[s][pos_m];
          di = pend_im[s][pos_m];
          mr = clampw((dr * tw_re[pos_m] - di * tw_im[pos_m] + (1 << (FRAC - 1))) >>> FRAC);
          mi = clampw((dr * tw_im[pos_m] + di * tw_re[pos_m] + (1 << (FRAC - 1))) >>> FRAC);
          push_exp(s, mr, mi, D + pos_m, edge_n + 1);
        end
      end
    end else begin
      k = pos_m - D;
      for (int s = 0; s < 2; s++) begin
        push_exp(s, fit(cur_re[k] + re, s), fit(cur_im[k] + im, s), k, edge_n + 1);
        pend_re[s][k] = fit(cur_re[k] - re, s);
        pend_im[s][k] = fit(cur_im[k] - im, s);
      end
      primed_m = 1'b1;
    end
    pos_m = (pos_m + 1) % N;
  endtask

  task automatic expect_eq(string name, int act, int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic check_out(int s, logic v, logic [2*W-1:0] d, logic [IW-1:0] idx);
    exp_t e;
    int   qs;
    if (v) begin
      tests++;
      qs = (s == 0) ? q0.size() : q1.size();
      if (qs == 0) begin
        fails++;
        $display("FAIL unexpected_out dut%0d: out_valid=1 data=%h idx=%0d cycle=%0d, required no output",
                 s, d, idx, cyc);
      end else begin
        if (s == 0) e = q0.pop_front();
        else e = q1.pop_front();
        if (d !== e.data || idx !== IW'(e.idx) || cyc != e.due) begin
          fails++;
          $display("FAIL out dut%0d: data=%h idx=%0d cycle=%0d, required data=%h idx=%0d cycle=%0d",
                   s, d, idx, cyc, e.data, e.idx, e.due);
        end
      end
    end
  endtask

  // Monitor: every presented output must match the head of its queue.
  always @(negedge clk) begin
    check_out(0, bus0.out_valid, bus0.out_data, bus0.out_idx);
    check_out(1, bus1.out_valid, bus1.out_data, bus1.out_idx);
  end

  task automatic step(bit v, int re, int im);
    bus0.in_valid = v;
    bus1.in_valid = v;
    bus0.in_data  = {W'(re), W'(im)};
    bus1.in_data  = {W'(re), W'(im)};
    @(posedge clk);
    #1;
    if (v) model_accept(re, im, cyc);
  endtask

  task automatic idle();
    step(1'b0, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
  endtask

  task automatic rand_in();
    step(1'b1, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
  endtask

  // Reset with a sample offered at the same time; the sample must be ignored.
  task automatic do_reset();
    int r;
    rst = 1'b1;
    bus0.in_valid = 1'b1;
    bus1.in_valid = 1'b1;
    bus0.in_data  = 16'h5a3c;
    bus1.in_data  = 16'h5a3c;
    @(posedge clk);
    #1;
    r   = cyc;
    rst = 1'b0;
    bus0.in_valid = 1'b0;
    bus1.in_valid = 1'b0;
    while (q0.size() > 0 && q0[q0.size() - 1].due >= r) void'(q0.pop_back());
    while (q1.size() > 0 && q1[q1.size() - 1].due >= r) void'(q1.pop_back());
    model_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      expect_eq("post_rst_valid0", int'(bus0.out_valid), 0);
      expect_eq("post_rst_valid1", int'(bus1.out_valid), 0);
    end
  endtask

  task automatic frame_impulse();
    step(1'b1, 16, 0);
    for (int i = 1; i < N; i++) step(1'b1, 0, 0);
    for (int i = 0; i < N; i++) step(1'b1, 0, 0);
  endtask

  initial begin
    for (int k = 0; k < D; k++) begin
      tw_re[k] = rnd(real'(1 << FRAC) * $cos(3.14159265358979323846 * real'(k) / real'(D)));
      tw_im[k] = -rnd(real'(1 << FRAC) * $sin(3.14159265358979323846 * real'(k) / real'(D)));
    end
    model_reset();
    bus0.in_valid = 1'b0;
    bus1.in_valid = 1'b0;
    bus0.in_data  = 16'h0000;
    bus1.in_data  = 16'h0000;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    expect_eq("rst_out_valid0", int'(bus0.out_valid), 0);
    expect_eq("rst_out_data0",  int'(bus0.out_data), 0);
    expect_eq("rst_out_idx0",   int'(bus0.out_idx), 0);
    expect_eq("rst_out_valid1", int'(bus1.out_valid), 0);
    expect_eq("rst_out_data1",  int'(bus1.out_data), 0);
    expect_eq("rst_out_idx1",   int'(bus1.out_idx), 0);

    frame_impulse();

    for (int i = 0; i < 2 * N; i++) step(1'b1, 10, -3);

    for (int i = 0; i < N; i++) step(1'b1, (i == 1) ? 32 : 0, 0);
    for (int i = 0; i < N; i++) step(1'b1, 0, 0);

    for (int i = 0; i < N; i++) begin
      if (i == 0 || i == D) step(1'b1, 100, -100);
      else step(1'b1, 0, 0);
    end
    for (int i = 0; i < N; i++) step(1'b1, 0, 0);

    for (int i = 0; i < 2 * N; i++) begin
      step(1'b1, 10, -3);
      idle();
    end

    for (int i = 0; i < 5; i++) rand_in();
    do_reset();
    frame_impulse();

    for (int f = 0; f < 6; f++) begin
      for (int p = 0; p < N; p++) begin
        while ($urandom_range(0, 3) == 0) idle();
        rand_in();
      end
    end

    for (int i = 0; i < D; i++) step(1'b1, 0, 0);
    repeat (4) idle();

    expect_eq("pending_dut0", q0.size(), 0);
    expect_eq("pending_dut1", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
